imc_seq_ctrl: RTL and testbench
===============================

Name: imc_seq_ctrl

Overview:
- Command sequencer that drives the IMC macro's write_en, read_en, mac_en, bankde, Wxin and Wwbank, and captures its 14-bit result.
- Accepts one job per command over a valid/ready handshake. A job optionally streams four load beats (x vector plus weight bank k), then runs a read, a MAC and a result capture.
- Returns the result on a valid/ready output port.
- Sits between the host/DMA side and the imc instance.

Parameters:
- RD_LAT, 1: cycles waited after the read_en pulse before mac_en is issued (range 0-7).
- MAC_LAT, 2: cycles from the mac_en pulse to the cycle in which result is sampled (range 1-15).

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- cmd_valid  in  1  job request
- cmd_ready  out  1  controller idle and able to accept a job
- cmd_load  in  1  1 = load four beats then compute; 0 = compute on the stored data
- din_valid  in  1  load beat valid
- din_ready  out  1  controller accepts a load beat
- din_x  in  4x16  16 x-nibbles for this beat
- din_w  in  4x16  16 weight nibbles for bank beat_idx
- write_en  out  1  to imc
- read_en  out  1  to imc
- mac_en  out  1  to imc
- bankde  out  2  to imc, bank select
- Wxin  out  4x16  to imc, registered
- Wwbank  out  4x16  to imc, registered
- result  in  14  from imc
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_data  out  14  captured result
- err  out  1  one-cycle pulse: compute-only command issued while nothing is loaded
- busy  out  1  state is not IDLE

Behaviour:
- Reset (rst low, async):
  - state = IDLE, beat_idx = 0, loaded = 0.
  - All outputs are 0 except cmd_ready = 1.
  - Reset mid-job aborts the job. No partial result is emitted, and loaded is cleared.
- All imc-facing outputs are registered; write_en, read_en and mac_en are single-cycle pulses.
- States: IDLE, LOAD, READ, RWAIT, MAC, MWAIT, DONE.
- IDLE:
  - cmd_ready = 1. Handshake on cmd_valid & cmd_ready at cycle T0.
  - cmd_load = 1: go to LOAD, beat_idx = 0.
  - cmd_load = 0 and loaded = 1: go to READ.
  - cmd_load = 0 and loaded = 0: stay in IDLE and pulse err at T1.
- LOAD:
  - din_ready = 1.
  - On a din handshake in cycle t, at t+1: write_en = 1, bankde = beat_idx, Wxin = din_x, Wwbank = din_w.
  - beat_idx increments on each handshake. Beats are bank 0, 1, 2, 3 in order.
  - din_valid low means no write and beat_idx holds; stalls are unbounded.
  - On the 4th handshake: loaded is set and the next state is READ.
  - Wxin/Wwbank hold their last value when no write is in progress.
- READ: read_en = 1 for one cycle.
  - For a load job, read_en is the cycle after the last write_en.
  - For a compute-only job, read_en is at T1.
- RWAIT: waits RD_LAT cycles. With RD_LAT = 0 it is skipped.
- MAC: mac_en = 1 for one cycle.
- MWAIT: counter runs MAC_LAT cycles. result is sampled into res_data at the cycle that is MAC_LAT cycles after the mac_en cycle.
- DONE:
  - res_valid = 1 starting the cycle after sampling. res_data is stable while res_valid is high.
  - On res_valid & res_ready, res_valid clears and the next state is IDLE; cmd_ready is 1 the cycle after.
- Default timing, compute-only (T0 = command accept): read_en T1, mac_en T3, sample T5, res_valid T6.
- Default timing, load with back-to-back beats (din handshakes T1–T4): write_en T2–T5, read_en T6, mac_en T8, sample T10, res_valid T11.
- Busy-time rules:
  - cmd_ready = 0 in every state except IDLE; cmd_valid is ignored there.
  - din_valid outside LOAD is ignored, with din_ready = 0.
  - Back-to-back jobs: a new command can be accepted the cycle after the result handshake.
- Counters saturate at their terminal value; there is no wrap-around.

Test Plan:
- Reset, then a load job: beats with x = k+1 in all lanes and w = 2 in all lanes. Back-to-back handshakes at T1–T4 give write_en at T2–T5 with bankde 0,1,2,3. read_en at T6, mac_en at T8, result = 0x123 captured, res_valid at T11, res_data = 0x123.
- Compute-only command after a load: read_en at T1, mac_en at T3, res_valid at T6. The result from imc is captured unchanged.
- Compute-only command after reset: no read/mac pulses, err = 1 for one cycle at T1, cmd_ready stays 1.
- Load with din_valid dropped for 3 cycles after beat 1: no write_en during the gap, beat 2 lands on bankde = 2. Total latency is extended by exactly 3 cycles.
- res_ready held low for 5 cycles: res_valid and res_data stay stable and a cmd_valid pulse is ignored. After res_ready rises, the next command is accepted one cycle later.
- rst asserted during MWAIT: all outputs are 0 immediately, cmd_ready = 1. A following compute-only command raises err, because loaded was cleared.

Source files
------------

// File: rtl/imc_seq_ctrl.sv
// imc_seq_ctrl: command sequencer for the IMC macro.
// Accepts one job per command (optional 4-beat load of x vector + weight
// banks, then read, MAC and result capture) and returns the 14-bit result
// over a valid/ready port.
// Ports:
//   clk, rst                  clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_load   job request handshake
//   din_valid/din_ready/din_x/din_w load beat handshake and payload
//   write_en/read_en/mac_en/bankde/Wxin/Wwbank  registered imc controls
//   result                    imc result input
//   res_valid/res_ready/res_data   result handshake
//   err                       pulse: compute-only job with nothing loaded
//   busy                      controller not idle
module imc_seq_ctrl #(
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [15:0][3:0] din_x,
  input  logic [15:0][3:0] din_w,
  output logic             write_en,
  output logic             read_en,
  output logic             mac_en,
  output logic [1:0]       bankde,
  output logic [15:0][3:0] Wxin,
  output logic [15:0][3:0] Wwbank,
  input  logic [13:0]      result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [13:0]      res_data,
  output logic             err,
  output logic             busy
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned BEAT_W    = 3;
  localparam int unsigned NUM_BEATS = 4;

  typedef enum logic [2:0] {
    IDLE, LOAD, READ, RWAIT, MAC, MWAIT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                loaded_q, loaded_d;

  logic                cmd_ready_d, din_ready_d, write_en_d, read_en_d;
  logic                mac_en_d, res_valid_d, err_d, busy_d;
  logic [1:0]          bankde_d;
  logic [15:0][3:0]    wxin_d, wwbank_d;
  logic [13:0]         res_data_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      cnt_q     <= '0;
      loaded_q  <= 1'b0;
      cmd_ready <= 1'b1;
      din_ready <= 1'b0;
      write_en  <= 1'b0;
      read_en   <= 1'b0;
      mac_en    <= 1'b0;
      bankde    <= '0;
      Wxin      <= '0;
      Wwbank    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      loaded_q  <= loaded_d;
      cmd_ready <= cmd_ready_d;
      din_ready <= din_ready_d;
      write_en  <= write_en_d;
      read_en   <= read_en_d;
      mac_en    <= mac_en_d;
      bankde    <= bankde_d;
      Wxin      <= wxin_d;
      Wwbank    <= wwbank_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
      err       <= err_d;
      busy      <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    loaded_d   = loaded_q;
    write_en_d = 1'b0;
    err_d      = 1'b0;
    bankde_d   = bankde;
    wxin_d     = Wxin;
    wwbank_d   = Wwbank;
    res_data_d = res_data;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_load) begin
            state_d = LOAD;
            beat_d  = '0;
          end else if (loaded_q) begin
            state_d = READ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        // beat_q parks at NUM_BEATS for one cycle so read_en follows
        // the last write_en pulse rather than overlapping it
        if (beat_q == BEAT_W'(NUM_BEATS)) begin
          state_d = READ;
        end else if (din_valid) begin
          write_en_d = 1'b1;
          bankde_d   = beat_q[1:0];
          wxin_d     = din_x;
          wwbank_d   = din_w;
          beat_d     = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(NUM_BEATS - 1)) loaded_d = 1'b1;
        end
      end
      READ: begin
        if (RD_LAT == 0) begin
          state_d = MAC;
        end else begin
          state_d = RWAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      RWAIT: begin
        if (cnt_q >= CNT_W'(RD_LAT)) state_d = MAC;
        else if (cnt_q != '1)        cnt_d   = cnt_q + CNT_W'(1);
      end
      MAC: begin
        state_d = MWAIT;
        cnt_d   = CNT_W'(1);
      end
      MWAIT: begin
        if (cnt_q >= CNT_W'(MAC_LAT)) begin
          res_data_d = result;
          state_d    = DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Level outputs and one-shot strobes follow the state being entered
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    din_ready_d = (state_d == LOAD) && (beat_d < BEAT_W'(NUM_BEATS));
    read_en_d   = (state_d == READ);
    mac_en_d    = (state_d == MAC);
    res_valid_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_imc_seq_ctrl.sv
// Self-checking bench for imc_seq_ctrl: random jobs, expected pulse
// schedule and result scoreboard derived from the job timing rules.
module tb_imc_seq_ctrl;

  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned MAC_LAT = 2;
  localparam int NCYC = 8192;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_load;
  logic             din_valid, din_ready;
  logic [15:0][3:0] din_x, din_w;
  logic             write_en, read_en, mac_en;
  logic [1:0]       bankde;
  logic [15:0][3:0] Wxin, Wwbank;
  logic [13:0]      result = '0;
  logic             res_valid, res_ready;
  logic [13:0]      res_data;
  logic             err, busy;

  imc_seq_ctrl #(.RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .din_valid(din_valid), .din_ready(din_ready), .din_x(din_x), .din_w(din_w),
    .write_en(write_en), .read_en(read_en), .mac_en(mac_en), .bankde(bankde),
    .Wxin(Wxin), .Wwbank(Wwbank), .result(result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle schedule, filled by the driver ahead of time
  bit               exp_wr [NCYC];
  bit               exp_rd [NCYC];
  bit               exp_mac[NCYC];
  bit               exp_err[NCYC];
  logic [1:0]       exp_bank[NCYC];
  logic [15:0][3:0] exp_x[NCYC];
  logic [15:0][3:0] exp_w[NCYC];
  logic [13:0]      res_tab[NCYC];

  typedef struct {
    int          vcyc;
    logic [13:0] data;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;
  bit model_loaded = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  // imc model: the macro's result bus carries a random value per cycle
  always begin
    @(posedge clk);
    #1;
    result = res_tab[cyc % NCYC];
  end

  // Monitor: compares strobes, write payload and result port every cycle
  logic [15:0][3:0] hold_x = '0;
  logic [15:0][3:0] hold_w = '0;
  bit               prev_rv = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      hold_x  = '0;
      hold_w  = '0;
      prev_rv = 1'b0;
    end else begin
      if (exp_wr[cyc]) begin
        hold_x = exp_x[cyc];
        hold_w = exp_w[cyc];
        chk("bankde", 64'(bankde), 64'(exp_bank[cyc]));
      end
      chk("write_en", 64'(write_en), 64'(exp_wr[cyc]));
      chk("read_en", 64'(read_en), 64'(exp_rd[cyc]));
      chk("mac_en", 64'(mac_en), 64'(exp_mac[cyc]));
      chk("err", 64'(err), 64'(exp_err[cyc]));
      chk("Wxin", Wxin, hold_x);
      chk("Wwbank", Wwbank, hold_w);
      if (res_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious res_valid", 64'(res_valid), 64'(0));
        end else begin
          if (!prev_rv) chk("res_valid start cycle", 64'(cyc), 64'(sbq[0].vcyc));
          chk("res_data", 64'(res_data), 64'(sbq[0].data));
          chk("busy in DONE", 64'(busy), 64'(1));
          if (res_ready) void'(sbq.pop_front());
        end
      end else if (sbq.size() > 0 && cyc == sbq[0].vcyc) begin
        chk("res_valid missing", 64'(res_valid), 64'(1));
      end
      prev_rv = res_valid && !res_ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One job: gaps[b] idle cycles before beat b, hold = res_ready low cycles
  task automatic run_job(input bit load, input bit pat, input logic [3:0][3:0] gaps,
                         input int hold, input bit abort);
    int t0, gsum, rd, mc, smp, n, bc;
    n = 0;
    while (!cmd_ready && n < 100) begin step(); n++; end
    if (!cmd_ready) begin
      chk("cmd_ready wait timeout", 64'(cmd_ready), 64'(1));
      return;
    end
    cmd_valid = 1'b1;
    cmd_load  = load;
    t0 = cyc;
    if (!load && !model_loaded) begin
      exp_err[t0+1] = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("cmd_ready after err", 64'(cmd_ready), 64'(1));
      return;
    end
    gsum = 0;
    if (load) for (int b = 0; b < 4; b++) gsum += int'(gaps[b]);
    rd  = load ? (t0 + 6 + gsum) : (t0 + 1);
    mc  = rd + 1 + int'(RD_LAT);
    smp = mc + int'(MAC_LAT);
    exp_rd[rd]  = 1'b1;
    exp_mac[mc] = 1'b1;
    sbq.push_back('{smp + 1, res_tab[smp]});
    step();
    cmd_valid = 1'b0;
    if (load) begin
      for (int b = 0; b < 4; b++) begin
        for (int g = 0; g < int'(gaps[b]); g++) begin
          din_valid = 1'b0;
          step();
        end
        din_valid = 1'b1;
        for (int l = 0; l < 16; l++) begin
          din_x[l] = pat ? 4'(b + 1) : 4'($urandom);
          din_w[l] = pat ? 4'd2 : 4'($urandom);
        end
        chk("din_ready in LOAD", 64'(din_ready), 64'(1));
        bc = cyc + 1;
        exp_wr[bc]   = 1'b1;
        exp_bank[bc] = 2'(b);
        exp_x[bc]    = din_x;
        exp_w[bc]    = din_w;
        step();
      end
      din_valid = 1'b0;
      chk("din_ready after beat 4", 64'(din_ready), 64'(0));
      model_loaded = 1'b1;
    end
    if (abort) begin
      while (cyc < mc + 1) step();
      rst = 1'b0;
      #1;
      chk("abort cmd_ready", 64'(cmd_ready), 64'(1));
      chk("abort busy", 64'(busy), 64'(0));
      chk("abort strobes", 64'({write_en, read_en, mac_en, err, res_valid, din_ready}), 64'(0));
      chk("abort bankde", 64'(bankde), 64'(0));
      chk("abort Wxin", Wxin, 64'(0));
      chk("abort Wwbank", Wwbank, 64'(0));
      chk("abort res_data", 64'(res_data), 64'(0));
      void'(sbq.pop_back());
      model_loaded = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      return;
    end
    if (hold > 0) begin
      res_ready = 1'b0;
      n = 0;
      while (cyc < smp + 1 + hold && n < 300) begin
        if (cyc == smp + 2) begin
          cmd_valid = 1'b1;
          cmd_load  = 1'b1;
        end else begin
          cmd_valid = 1'b0;
        end
        step();
        n++;
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
    end
    n = 0;
    while (!res_valid && n < 300) begin step(); n++; end
    if (!res_valid) begin
      chk("res_valid timeout", 64'(res_valid), 64'(1));
      return;
    end
    step();
    chk("cmd_ready after result", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    logic [3:0][3:0] gz;
    logic [3:0][3:0] gr;
    for (int i = 0; i < NCYC; i++) res_tab[i] = 14'($urandom);
    gz = '0;
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    din_valid = 1'b0;
    din_x     = '0;
    din_w     = '0;
    res_ready = 1'b1;
    repeat (3) step();
    chk("reset cmd_ready", 64'(cmd_ready), 64'(1));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset strobes", 64'({write_en, read_en, mac_en, err, res_valid, din_ready}), 64'(0));
    chk("reset res_data", 64'(res_data), 64'(0));
    rst = 1'b1;
    step();

    run_job(1'b0, 1'b0, gz, 0, 1'b0);               // err: nothing loaded
    run_job(1'b1, 1'b1, gz, 0, 1'b0);               // patterned load job
    run_job(1'b0, 1'b0, gz, 0, 1'b0);               // compute-only
    gr = '0;
    gr[2] = 4'd3;
    run_job(1'b1, 1'b0, gr, 0, 1'b0);               // 3-cycle stall before bank 2
    run_job(1'b0, 1'b0, gz, 5, 1'b0);               // res_ready held low
    for (int j = 0; j < 25; j++) begin
      for (int b = 0; b < 4; b++) gr[b] = 4'($urandom_range(0, 2));
      run_job(1'($urandom), 1'b0, gr, int'($urandom_range(0, 3)), 1'b0);
    end
    run_job(1'b1, 1'b0, gz, 0, 1'b1);               // reset during MWAIT
    run_job(1'b0, 1'b0, gz, 0, 1'b0);               // err after abort
    repeat (6) step();
    chk("scoreboard drained", 64'(sbq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
